// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS panel power sequencer.
//   panel_state_e  : sequencer state encoding (also exported on the debug port)
//   panel_out_t    : registered output bundle {vdd, lvds, bl, ready}
//   state_outputs(): output levels implied by a state
//   DEF_*          : default timing constants (DotClock cycles)
package lvds_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_VDD_UP    = 3'd1,
    ST_SYNC_WAIT = 3'd2,
    ST_LVDS_UP   = 3'd3,
    ST_ON        = 3'd4,
    ST_BL_DOWN   = 3'd5,
    ST_LVDS_DOWN = 3'd6,
    ST_OFF_WAIT  = 3'd7
  } panel_state_e;

  typedef struct packed {
    logic vdd;
    logic lvds;
    logic bl;
    logic ready;
  } panel_out_t;

  localparam int unsigned DEF_CNT_W      = 24;
  localparam int unsigned DEF_T_VDD_LVDS = 500000;
  localparam int unsigned DEF_T_LVDS_BL  = 1000000;
  localparam int unsigned DEF_T_BL_LVDS  = 1000000;
  localparam int unsigned DEF_T_LVDS_VDD = 500000;
  localparam int unsigned DEF_T_OFF_MIN  = 5000000;
  localparam int unsigned DEF_PWM_DIV    = 16;

  function automatic panel_out_t state_outputs(input panel_state_e s);
    panel_out_t o;
    o = '0;
    case (s)
      ST_VDD_UP, ST_SYNC_WAIT, ST_LVDS_DOWN: o.vdd = 1'b1;
      ST_LVDS_UP, ST_BL_DOWN: begin
        o.vdd  = 1'b1;
        o.lvds = 1'b1;
      end
      ST_ON: o = '1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lvds_bl_pwm.sv
// Backlight brightness PWM.
//   clk, rst    : DotClock and async active-high reset
//   bl_en       : registered backlight enable from the sequencer
//   brightness  : duty code, sampled only when pwm_cnt wraps 255->0
//   bl_pwm      : registered PWM output, bl_en AND (pwm_cnt < latched code)
// Prescaler and pwm_cnt free-run from reset regardless of sequencer state.
module lvds_bl_pwm
  import lvds_pkg::*;
#(
  parameter int unsigned PWM_DIV = DEF_PWM_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bl_en,
  input  logic [7:0] brightness,
  output logic       bl_pwm
);

  localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       level_q, level_d;
  logic             pwm_q, pwm_d;
  logic             step;

  always_comb begin
    step    = (pre_q == PRE_W'(PWM_DIV - 1));
    pre_d   = step ? '0 : pre_q + PRE_W'(1);
    cnt_d   = step ? cnt_q + 8'd1 : cnt_q;
    // New duty only takes effect at the start of a full PWM period.
    level_d = (step && (cnt_q == 8'hFF)) ? brightness : level_q;
    pwm_d   = bl_en && (cnt_q < level_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pwm_q   <= pwm_d;
    end
  end

  assign bl_pwm = pwm_q;

endmodule

// File: rtl/lvds_panel_sequencer.sv
// LVDS TFT panel power/enable sequencer (DotClock domain).
//   clk, rst      : DotClock and async active-high reset
//   enable        : level request, 1 = panel on
//   vsync_in      : VSync, synchronous to clk; LVDS start aligns to its rise
//   brightness    : backlight duty code
//   panel_vdd_en, lvds_en, bl_en, bl_pwm : registered board-level enables
//   ready         : panel fully on
//   state         : current sequencer state (debug)
module lvds_panel_sequencer
  import lvds_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned T_VDD_LVDS = DEF_T_VDD_LVDS,
  parameter int unsigned T_LVDS_BL  = DEF_T_LVDS_BL,
  parameter int unsigned T_BL_LVDS  = DEF_T_BL_LVDS,
  parameter int unsigned T_LVDS_VDD = DEF_T_LVDS_VDD,
  parameter int unsigned T_OFF_MIN  = DEF_T_OFF_MIN,
  parameter int unsigned PWM_DIV    = DEF_PWM_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       vsync_in,
  input  logic [7:0] brightness,
  output logic       panel_vdd_en,
  output logic       lvds_en,
  output logic       bl_en,
  output logic       bl_pwm,
  output logic       ready,
  output logic [2:0] state
);

  panel_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vsync_q;
  panel_out_t       out_q, out_d;
  logic             cnt_zero;
  logic             vsync_rise;

  // Counter load for a dwell of t cycles: exit happens the cycle after 0.
  function automatic logic [CNT_W-1:0] dwell(input int unsigned t);
    return CNT_W'(t - 1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF_WAIT;
      cnt_q   <= dwell(T_OFF_MIN);
      vsync_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vsync_q <= vsync_in;
      out_q   <= out_d;
    end
  end

  always_comb begin
    cnt_zero   = (cnt_q == '0);
    vsync_rise = vsync_in && !vsync_q;
    state_d    = state_q;
    cnt_d      = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
    case (state_q)
      ST_OFF: begin
        if (enable) begin
          state_d = ST_VDD_UP;
          cnt_d   = dwell(T_VDD_LVDS);
        end
      end
      ST_VDD_UP: begin
        if (!enable) begin
          state_d = ST_OFF_WAIT;
          cnt_d   = dwell(T_OFF_MIN);
        end else if (cnt_zero) begin
          state_d = ST_SYNC_WAIT;
        end
      end
      ST_SYNC_WAIT: begin
        if (!enable) begin
          state_d = ST_OFF_WAIT;
          cnt_d   = dwell(T_OFF_MIN);
        end else if (vsync_rise) begin
          state_d = ST_LVDS_UP;
          cnt_d   = dwell(T_LVDS_BL);
        end
      end
      ST_LVDS_UP: begin
        // Abort skips BL_DOWN: the backlight was never lit.
        if (!enable) begin
          state_d = ST_LVDS_DOWN;
          cnt_d   = dwell(T_LVDS_VDD);
        end else if (cnt_zero) begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (!enable) begin
          state_d = ST_BL_DOWN;
          cnt_d   = dwell(T_BL_LVDS);
        end
      end
      ST_BL_DOWN: begin
        if (cnt_zero) begin
          state_d = ST_LVDS_DOWN;
          cnt_d   = dwell(T_LVDS_VDD);
        end
      end
      ST_LVDS_DOWN: begin
        if (cnt_zero) begin
          state_d = ST_OFF_WAIT;
          cnt_d   = dwell(T_OFF_MIN);
        end
      end
      ST_OFF_WAIT: begin
        if (cnt_zero) state_d = ST_OFF;
      end
      default: state_d = ST_OFF_WAIT;
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    out_d = state_outputs(state_d);
  end

  lvds_bl_pwm #(
    .PWM_DIV(PWM_DIV)
  ) u_bl_pwm (
    .clk       (clk),
    .rst       (rst),
    .bl_en     (out_q.bl),
    .brightness(brightness),
    .bl_pwm    (bl_pwm)
  );

  assign panel_vdd_en = out_q.vdd;
  assign lvds_en      = out_q.lvds;
  assign bl_en        = out_q.bl;
  assign ready        = out_q.ready;
  assign state        = state_q;

endmodule

// File: tb/tb_lvds_panel_sequencer.sv
module tb_lvds_panel_sequencer;

  localparam int T1    = 10;
  localparam int T2    = 5;
  localparam int T3    = 4;
  localparam int T4    = 6;
  localparam int T5    = 8;
  localparam int P_DIV = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       vs_auto = 1'b1;
  logic       vs_man = 1'b0;
  logic       vs_gen = 1'b0;
  wire        vsync_in = vs_auto ? vs_gen : vs_man;
  logic [7:0] brightness = 8'd64;
  logic       panel_vdd_en, lvds_en, bl_en, bl_pwm, ready;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  lvds_panel_sequencer #(
    .CNT_W     (24),
    .T_VDD_LVDS(T1),
    .T_LVDS_BL (T2),
    .T_BL_LVDS (T3),
    .T_LVDS_VDD(T4),
    .T_OFF_MIN (T5),
    .PWM_DIV   (P_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .vsync_in    (vsync_in),
    .brightness  (brightness),
    .panel_vdd_en(panel_vdd_en),
    .lvds_en     (lvds_en),
    .bl_en       (bl_en),
    .bl_pwm      (bl_pwm),
    .ready       (ready),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // VSync: 4-cycle pulse every 40 cycles, first one right after reset release.
  always @(negedge clk) vs_gen = ((cyc % 40) < 4);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Which outputs are on in each state, indexed by state number.
  logic [7:0] vdd_set  = 8'b0111_1110;
  logic [7:0] lvds_set = 8'b0011_1000;
  logic [7:0] bl_set   = 8'b0001_0000;

  int         m_st = 7;
  int         m_el = 0;     // edges spent in the current state
  int         m_tick = 0;   // edges since reset release (drives PWM phase)
  int         nst;
  logic       m_vsp = 1'b0;
  logic       m_pwm = 1'b0;
  logic [7:0] m_lvl = 8'd0;
  logic       rise, pw_next;

  function automatic int pwm_phase(input int t);
    return (t / P_DIV) % 256;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 7; m_el = 0; m_tick = 0; m_vsp = 1'b0; m_pwm = 1'b0; m_lvl = 8'd0;
    end else begin
      rise    = vsync_in && !m_vsp;
      pw_next = bl_set[m_st[2:0]] && (pwm_phase(m_tick) < int'(m_lvl));
      m_el    = m_el + 1;
      nst     = m_st;
      case (m_st)
        0: if (enable) nst = 1;
        1: if (!enable) nst = 7; else if (m_el >= T1) nst = 2;
        2: if (!enable) nst = 7; else if (rise) nst = 3;
        3: if (!enable) nst = 6; else if (m_el >= T2) nst = 4;
        4: if (!enable) nst = 5;
        5: if (m_el >= T3) nst = 6;
        6: if (m_el >= T4) nst = 7;
        default: if (m_el >= T5) nst = 0;
      endcase
      if (nst != m_st) m_el = 0;
      m_st   = nst;
      m_tick = m_tick + 1;
      if ((m_tick % (256 * P_DIV)) == 0) m_lvl = brightness;
      m_pwm  = pw_next;
      m_vsp  = vsync_in;
    end
  end

  // Per-cycle comparison against the model plus the enable invariants.
  always @(negedge clk) begin
    check("state", {29'b0, state}, m_st);
    check("panel_vdd_en", {31'b0, panel_vdd_en}, {31'b0, vdd_set[m_st[2:0]]});
    check("lvds_en", {31'b0, lvds_en}, {31'b0, lvds_set[m_st[2:0]]});
    check("bl_en", {31'b0, bl_en}, {31'b0, bl_set[m_st[2:0]]});
    check("ready", {31'b0, ready}, {31'b0, bl_set[m_st[2:0]]});
    check("bl_pwm", {31'b0, bl_pwm}, {31'b0, m_pwm});
    check("inv_bl_implies_lvds", {31'b0, bl_en & ~lvds_en}, 0);
    check("inv_lvds_implies_vdd", {31'b0, lvds_en & ~panel_vdd_en}, 0);
  end

  // ---------------- directed + random stimulus ----------------
  function automatic logic [31:0] sig(input int sel);
    case (sel)
      0: return {31'b0, panel_vdd_en};
      1: return {31'b0, lvds_en};
      2: return {31'b0, bl_en};
      default: return {29'b0, state};
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic [31:0] val, input int bound, input string name);
    int n;
    n = 0;
    while (sig(sel) !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sig(sel) !== val) check({name, "_timeout"}, sig(sel), val);
  endtask

  task automatic count_pwm(input int chg_at, input logic [7:0] new_b, output int hi);
    hi = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      hi += int'(bl_pwm);
      if (i == chg_at) brightness = new_b;
    end
  endtask

  int hi, vdd_hi, bad;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", {29'b0, state}, 7);
    check("rst_outputs", {27'b0, panel_vdd_en, lvds_en, bl_en, bl_pwm, ready}, 0);
    rst = 1'b0;

    // Power-up with enable held high.
    wait_for(0, 1, 100, "vdd_up");
    check("vdd_rise_cycle", cyc, 9);
    wait_for(1, 1, 100, "lvds_up");
    check("lvds_rise_cycle", cyc, 41);
    wait_for(2, 1, 100, "bl_up");
    check("bl_rise_cycle", cyc, 46);
    check("ready_on", {31'b0, ready}, 1);

    // Power-down from ON; enable re-raised during OFF_WAIT.
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("bl_fall_next", {31'b0, bl_en}, 0);
    check("bl_down_state", {29'b0, state}, 5);
    wait_for(1, 0, 100, "lvds_down");
    check("lvds_fall_cycle", cyc, 54);
    wait_for(0, 0, 100, "vdd_down");
    check("vdd_fall_cycle", cyc, 60);
    enable = 1'b1;
    vdd_hi = 0;
    repeat (8) begin
      @(negedge clk);
      vdd_hi += int'(panel_vdd_en);
    end
    check("vdd_low_in_off_wait", vdd_hi, 0);
    check("off_reached", {29'b0, state}, 0);
    @(negedge clk);
    check("repower_vdd", {31'b0, panel_vdd_en}, 1);

    // Abort 3 cycles into LVDS_UP.
    wait_for(1, 1, 100, "lvds_up2");
    check("lvds_rise2_cycle", cyc, 81);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_state", {29'b0, state}, 6);
    check("abort_lvds_bl", {30'b0, lvds_en, bl_en}, 0);
    wait_for(0, 0, 100, "vdd_down2");
    check("abort_vdd_fall_cycle", cyc, 90);

    // No VSync: sequencer parks in SYNC_WAIT.
    vs_auto = 1'b0;
    vs_man  = 1'b0;
    enable  = 1'b1;
    wait_for(3, 2, 100, "sync_wait");
    check("sync_wait_cycle", cyc, 109);
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (state !== 3'd2 || lvds_en !== 1'b0) bad++;
    end
    check("stuck_in_sync_wait", bad, 0);
    vs_man = 1'b1;
    @(negedge clk);
    vs_man = 1'b0;
    check("single_vsync_lvds", {31'b0, lvds_en}, 1);
    check("single_vsync_state", {29'b0, state}, 3);
    wait_for(2, 1, 100, "bl_up3");

    // PWM duty windows aligned to pwm_cnt wraps.
    bad = 0;
    while ((cyc % 256) != 0 && bad < 300) begin
      @(negedge clk);
      bad++;
    end
    check("pwm_align", cyc % 256, 0);
    count_pwm(-1, 8'd0, hi);
    check("pwm_duty_64", hi, 64);
    count_pwm(128, 8'd192, hi);
    check("pwm_duty_held_64", hi, 64);
    count_pwm(76, 8'd0, hi);
    check("pwm_duty_192", hi, 192);
    count_pwm(-1, 8'd0, hi);
    check("pwm_duty_0", hi, 0);

    // Randomised operation against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      vs_man = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 99) == 0) brightness = 8'($urandom_range(0, 255));
      if (i == 1500) begin
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    // Asynchronous reset while fully on.
    vs_auto = 1'b1;
    enable  = 1'b1;
    wait_for(2, 1, 600, "bl_up_final");
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", {29'b0, state}, 7);
    check("async_rst_outputs", {27'b0, panel_vdd_en, lvds_en, bl_en, bl_pwm, ready}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
